alu_iter: RTL

// - Parametrised, handshaked successor to the core's single-cycle ALU: one registered result per accepted operation.
// - Single-cycle ops (add/sub/logic/compare/shift) complete in 1 cycle; MUL/MULHU/DIVU/REMU iterate over WIDTH cycles.
// - Sits in the execute stage of the multi-cycle core; the stall logic keys off InReady/OutValid.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv_iter.sv | 88 ++++++++
 rtl/alu_iter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
//   - ALU_* op-code constants carried on ALUControl
//   - state_e: handshake FSM states
//   - is_mdu_op(): true for the multi-cycle mul/div op codes
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1010;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_DIVU  = 4'b1100;
    localparam logic [3:0] ALU_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    function automatic logic is_mdu_op(input logic [3:0] op);
        return op inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiplier / restoring divider.
//   clk, reset_n  clock, synchronous active-low reset
//   start_i       load operands and begin (one-cycle pulse)
//   div_i         1: divide, 0: multiply (sampled with start_i)
//   a_i, b_i      multiplier/dividend, multiplicand/divisor
//   done_o        high during the final iteration cycle
//   lo_o, hi_o    result of the final iteration, valid with done_o:
//                 mul -> product low/high, div -> quotient/remainder
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             div_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   sum, trial;

    // hi_q:lo_q is the 2*WIDTH accumulator. Multiply shifts right, adding the
    // multiplicand into the top half when the current multiplier bit is set.
    // Divide shifts left: hi_q is the partial remainder, lo_q shifts dividend
    // bits out and quotient bits in. A zero divisor always "fits", which yields
    // an all-ones quotient and the dividend as remainder with no special case.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        sum   = {1'b0, hi_q} + {1'b0, b_q};
        trial = {hi_q, lo_q[WIDTH-1]};
        if (div_q) begin
            if (trial >= {1'b0, b_q}) begin
                hi_d = WIDTH'(trial - {1'b0, b_q});
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else if (start_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
            div_q  <= div_i;
            hi_q   <= '0;
            lo_q   <= a_i;
            b_q    <= b_i;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // The last step's result is handed out combinationally so the caller can
    // register it on the same edge the iteration completes.
    assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule

// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU, single-cycle ops plus optional iterative mul/div.
//   clk, reset_n         clock, synchronous active-low reset
//   InValid / InReady    operand handshake; InReady only in IDLE
//   SrcA, SrcB           operands
//   ALUControl           op code (alu_pkg ALU_*)
//   OutValid / OutReady  result handshake; OutValid only in DONE
//   ALUResult, Zero      registered result and its zero flag
//   Busy                 iterative operation in progress
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MDU_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             mdu_start, mdu_done;
    logic [WIDTH-1:0] mdu_lo, mdu_hi, mdu_res;

    assign shamt = SrcB[SHW-1:0];

    // Mul/div codes fall to the default here, which also gives the 0 result
    // when the iterative unit is not built.
    always_comb begin
        alu_res = '0;
        case (ALUControl)
            ALU_ADD:  alu_res = SrcA + SrcB;
            ALU_SUB:  alu_res = SrcA - SrcB;
            ALU_AND:  alu_res = SrcA & SrcB;
            ALU_OR:   alu_res = SrcA | SrcB;
            ALU_XOR:  alu_res = SrcA ^ SrcB;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            ALU_SLL:  alu_res = SrcA << shamt;
            ALU_SRL:  alu_res = SrcA >> shamt;
            ALU_SRA:  alu_res = $signed(SrcA) >>> shamt;
            default:  alu_res = '0;
        endcase
    end

    assign mdu_start = (state_q == ST_IDLE) && InValid && MDU_EN && is_mdu_op(ALUControl);

    if (MDU_EN) begin : g_mdu
        alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
            .clk     (clk),
            .reset_n (reset_n),
            .start_i (mdu_start),
            .div_i   (ALUControl inside {ALU_DIVU, ALU_REMU}),
            .a_i     (SrcA),
            .b_i     (SrcB),
            .done_o  (mdu_done),
            .lo_o    (mdu_lo),
            .hi_o    (mdu_hi)
        );
    end else begin : g_no_mdu
        assign mdu_done = 1'b0;
        assign mdu_lo   = '0;
        assign mdu_hi   = '0;
    end

    assign mdu_res = (op_q inside {ALU_MULHU, ALU_REMU}) ? mdu_hi : mdu_lo;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_ADD;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (InValid) begin
                        op_q <= ALUControl;
                        if (mdu_start) begin
                            state_q <= ST_CALC;
                        end else begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_CALC: begin
                    if (mdu_done) begin
                        result_q <= mdu_res;
                        zero_q   <= (mdu_res == '0);
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OutReady) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign InReady   = (state_q == ST_IDLE);
    assign OutValid  = (state_q == ST_DONE);
    assign Busy      = (state_q == ST_CALC);
    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule
